found_reporter: RTL and testbench
=================================

# found_reporter

Collects hits from the array of search modules and reports them over a UART link. It sits directly downstream of the search-module array. It consumes the packed `found` vector and coefficient bus, serialises one frame per hit on `TX`, and returns a one-cycle `res` pulse to the reporting module so that module can resume.

## Interface

Parameters:
- `NUM_OF_TAPS`, 6: coefficient bytes per module.
- `NUM_OF_MODULES`, 30: number of search modules; must be 1..255.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200).

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `co_buf`  in  NUM_OF_MODULES\*NUM_OF_TAPS\*8: module i's coefficients at bits [(i+1)\*NUM_OF_TAPS\*8-1 -: NUM_OF_TAPS\*8].
- `found`  in  NUM_OF_MODULES: level; module i holds bit i high until it sees `res[i]`.
- `res`  out  NUM_OF_MODULES: one-hot, one-cycle release pulse.
- `TX`  out  1: UART 8N1, LSB first, idle high.
- `busy`  out  1: high whenever the state is not IDLE.
- `frame_count`  out  16: number of completed frames; wraps 0xFFFF→0.

## Operation

- Frame layout is NUM_OF_TAPS+2 bytes:
  - byte 0: header 0xA5;
  - byte 1: module index (8 bits);
  - then the captured coefficient slice, most significant byte first.
- FSM states: IDLE, CAPTURE, SEND, RELEASE, HOLD.
- **IDLE**
  - If `found` is non-zero, select the first set bit at index ≥ `rr_ptr`, wrapping to 0 and scanning upward.
  - Register the selected index, then go to CAPTURE.
- **CAPTURE**
  - Latch the selected `co_buf` slice into the frame shift register.
  - Set the byte counter to 0 and go to SEND.
  - Changes on `co_buf` after this cycle do not affect the frame.
- **SEND**
  - Hand bytes to the `uart_tx_byte` sub-module in order.
  - When the stop bit of the last byte completes, go to RELEASE.
- **RELEASE**
  - Drive `res[idx]` = 1 for exactly this cycle.
  - Increment `frame_count`.
  - Set `rr_ptr` = idx+1, or 0 if idx = NUM_OF_MODULES-1.
  - Go to HOLD.
- **HOLD**
  - Stay for 2 cycles, then go to IDLE.
  - This gives the released module time to drop `found`; `found` is ignored during HOLD.
- `found` bits asserted while a frame is in progress are not lost; they are served after returning to IDLE.
- Reset values:
  - `TX` = 1, `res` = 0, `busy` = 0, `frame_count` = 0;
  - `rr_ptr` = 0, state IDLE;
  - UART sub-module idle.
- Reset mid-frame:
  - the frame is abandoned;
  - `TX` is high on the cycle after `rst_n` is sampled low;
  - no `res` pulse is issued for the abandoned frame.

## Timing

- Cycle numbering starts at cycle 0, the cycle in which IDLE samples a non-zero `found`:
  - cycle 1: CAPTURE;
  - cycle 2: first byte loaded into the UART;
  - cycle 3: `TX` falls (start bit).
- Each byte occupies exactly 10\*CLKS_PER_BIT cycles.
- Bytes are back-to-back, with no idle bits between them.
- `res` pulse is asserted on the cycle after the last stop bit ends. Latency from that `res` pulse to the next possible start bit is 1 (RELEASE) + 2 (HOLD) + 3 (IDLE→start bit) cycles.
- Total frame length: (NUM_OF_TAPS+2)\*10\*CLKS_PER_BIT cycles.

## Structure

Shared package `reporter_pkg` holds:
- `HEADER_BYTE` = 8'hA5;
- the state enum `rep_state_t`;
- the function `frame_bytes(NUM_OF_TAPS)`.

Sub-module `uart_tx_byte`:
- 8N1 serialiser with a `load`/`ready` handshake;
- `ready` goes high in the same cycle the stop bit ends, so the next `load` is accepted with no gap;
- `CLKS_PER_BIT` parameter.

The top level contains the round-robin picker, the FSM, the frame shift register and the counters.

## Test plan

Use `CLKS_PER_BIT` = 4 for simulation speed.

1. **Single hit:** `found[3]` rises with slice 48'h0102030405AB.
   - `TX` decodes A5 03 01 02 03 04 05 AB.
   - `res[3]` pulses once, 1 cycle wide.
   - `frame_count` = 1.
2. **Simultaneous hits:** `found[2]` and `found[7]` rise together from reset.
   - Frame for index 2, then frame for index 7.
   - `res[2]` pulse precedes `res[7]`.
3. **Round-robin:** `found[0]` and `found[29]` both held high, each re-raised immediately after its `res`.
   - Frames alternate 0, 29, 0, 29.
4. **Slice changes after capture:** `co_buf` slice is altered during SEND.
   - Transmitted bytes equal the values present in CAPTURE.
5. **Reset mid-frame:** `rst_n` low during byte 3.
   - `TX` = 1 next cycle; `res` = 0; `frame_count` = 0; `busy` = 0.
   - A new hit after release of reset produces a complete frame.
6. **Slow `found` drop:** module holds `found` high for 2 cycles after `res`, and is the only hit.
   - No duplicate frame during HOLD.
   - A single extra frame only if `found` is still high when IDLE is re-entered.

Source files
------------

// File: rtl/reporter_pkg.sv
// Shared definitions for found_reporter: frame header byte, FSM state encoding
// and frame sizing helper.
package reporter_pkg;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    SEND    = 3'd2,
    RELEASE = 3'd3,
    HOLD    = 3'd4
  } rep_state_t;

  function automatic int frame_bytes(input int num_of_taps);
    return num_of_taps + 2;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser, LSB first, idle high. ready rises in the final
// cycle of the stop bit so a new byte can follow with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] clk_q, clk_d;
  logic          tx_q, tx_d;
  logic          bit_end_s;

  assign bit_end_s = (clk_q == LAST_CLK);
  assign ready_o   = ~active_q | (bit_end_s & (bit_q == 4'd9));
  assign tx_o      = tx_q;

  // Bit timing and shifting; shift_q holds the remaining data bits plus the stop bit.
  always_comb begin
    active_d = active_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    clk_d    = clk_q;
    tx_d     = tx_q;
    if (ready_o && load_i) begin
      active_d = 1'b1;
      shift_d  = {1'b1, data_i};
      bit_d    = 4'd0;
      clk_d    = '0;
      tx_d     = 1'b0;
    end else if (!active_q) begin
      tx_d = 1'b1;
    end else if (!bit_end_s) begin
      clk_d = clk_q + 1'b1;
    end else if (bit_q == 4'd9) begin
      active_d = 1'b0;
      clk_d    = '0;
      tx_d     = 1'b1;
    end else begin
      clk_d   = '0;
      bit_d   = bit_q + 4'd1;
      tx_d    = shift_q[0];
      shift_d = {1'b1, shift_q[8:1]};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      shift_q  <= 9'h1FF;
      bit_q    <= 4'd0;
      clk_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      clk_q    <= clk_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/found_reporter.sv
// Collects hits from the search-module array, picks one round-robin, sends a
// UART frame (header, index, coefficients MSB first) and pulses res for it.
module found_reporter
  import reporter_pkg::*;
#(
  parameter int NUM_OF_TAPS    = 6,
  parameter int NUM_OF_MODULES = 30,
  parameter int CLKS_PER_BIT   = 434
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_OF_MODULES*NUM_OF_TAPS*8-1:0] co_buf,
  input  logic [NUM_OF_MODULES-1:0]              found,
  output logic [NUM_OF_MODULES-1:0]              res,
  output logic                                   TX,
  output logic                                   busy,
  output logic [15:0]                            frame_count
);

  localparam int SLICE_W = NUM_OF_TAPS * 8;
  localparam int FB      = frame_bytes(NUM_OF_TAPS);
  localparam int FRAME_W = FB * 8;
  localparam int BCW     = $clog2(FB + 1);
  localparam logic [BCW-1:0] LAST_BYTE_CNT = BCW'(FB);
  localparam logic [7:0]     LAST_IDX      = 8'(NUM_OF_MODULES - 1);

  rep_state_t                state_q, state_d;
  logic [7:0]                idx_q, idx_d;
  logic [7:0]                rr_q, rr_d;
  logic [FRAME_W-1:0]        frame_q, frame_d;
  logic [BCW-1:0]            byte_q, byte_d;
  logic                      hold_q, hold_d;
  logic [15:0]               fc_q, fc_d;
  logic [NUM_OF_MODULES-1:0] res_q, res_d;
  logic                      busy_q;
  logic [NUM_OF_MODULES-1:0] hi_s, release_hot_s;
  logic [7:0]                pick_s;
  logic                      uart_load_s, uart_ready_s, uart_tx_s;

  function automatic logic [7:0] lowest_set(input logic [NUM_OF_MODULES-1:0] vec);
    logic [7:0] idx;
    idx = 8'd0;
    for (int i = NUM_OF_MODULES - 1; i >= 0; i--) begin
      if (vec[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  // Round-robin pick: lowest hit at or above rr_q, otherwise wrap to the lowest hit.
  always_comb begin
    hi_s = '0;
    for (int i = 0; i < NUM_OF_MODULES; i++) begin
      hi_s[i] = found[i] & (8'(i) >= rr_q);
    end
    pick_s = (|hi_s) ? lowest_set(hi_s) : lowest_set(found);
  end

  // One-hot release vector for the module being served.
  always_comb begin
    release_hot_s = '0;
    for (int i = 0; i < NUM_OF_MODULES; i++) begin
      release_hot_s[i] = (idx_q == 8'(i));
    end
  end

  // Next-state logic; res and the counters update on entry to RELEASE so they
  // are visible during the RELEASE cycle itself.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    frame_d     = frame_q;
    byte_d      = byte_q;
    hold_d      = hold_q;
    fc_d        = fc_q;
    res_d       = '0;
    uart_load_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (|found) begin
          idx_d   = pick_s;
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        frame_d = {HEADER_BYTE, idx_q, co_buf[idx_q*SLICE_W +: SLICE_W]};
        byte_d  = '0;
        state_d = SEND;
      end
      SEND: begin
        if (!uart_ready_s) begin
          state_d = SEND;
        end else if (byte_q == LAST_BYTE_CNT) begin
          state_d = RELEASE;
          res_d   = release_hot_s;
          fc_d    = fc_q + 16'd1;
          rr_d    = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
        end else begin
          uart_load_s = 1'b1;
          frame_d     = {frame_q[FRAME_W-9:0], 8'h00};
          byte_d      = byte_q + BCW'(1);
        end
      end
      RELEASE: begin
        hold_d  = 1'b0;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_q) begin
          state_d = IDLE;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 8'd0;
      rr_q    <= 8'd0;
      frame_q <= '0;
      byte_q  <= '0;
      hold_q  <= 1'b0;
      fc_q    <= 16'd0;
      res_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      frame_q <= frame_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      fc_q    <= fc_d;
      res_q   <= res_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (uart_load_s),
    .data_i (frame_q[FRAME_W-1 -: 8]),
    .ready_o(uart_ready_s),
    .tx_o   (uart_tx_s)
  );

  assign res         = res_q;
  assign TX          = uart_tx_s;
  assign busy        = busy_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_found_reporter.sv
// Bench for found_reporter: a frame-timeline model predicts TX/res/busy/frame_count
// every cycle, and a UART decoder plus literal tables pin the frame contents.
`timescale 1ns/1ps
module tb_found_reporter;

  localparam int TAPS      = 6;
  localparam int NM        = 30;
  localparam int CPB       = 4;
  localparam int SW        = TAPS * 8;
  localparam int FB        = TAPS + 2;
  localparam int FRAME_CYC = FB * 10 * CPB;
  localparam int R         = 3 + FRAME_CYC;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NM*SW-1:0] co_buf = '0;
  logic [NM-1:0]    found = '0;
  logic [NM-1:0]    res;
  logic             tx, busy;
  logic [15:0]      frame_count;

  found_reporter #(
    .NUM_OF_TAPS(TAPS), .NUM_OF_MODULES(NM), .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .co_buf(co_buf), .found(found),
    .res(res), .TX(tx), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: a frame started by IDLE sampling at cycle t0 fixes every output by t.
  bit            m_active = 1'b0;
  int            m_t0 = 0, m_idx = 0, m_rr = 0;
  logic [SW-1:0] m_slice = '0;
  logic [15:0]   m_count = 16'd0;

  function automatic int pick(input logic [NM-1:0] f, input int from);
    for (int i = from; i < NM; i++) if (f[i]) return i;
    for (int i = 0; i < from; i++) if (f[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] frame_byte(input int k);
    if (k == 0) return 8'hA5;
    if (k == 1) return 8'(m_idx);
    return m_slice[(TAPS - 1 - (k - 2)) * 8 +: 8];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_rr     = 0;
      m_count  = 16'd0;
    end else begin
      if (m_active && (cyc - m_t0) >= R + 3) m_active = 1'b0;
      if (!m_active) begin
        if (found != '0) begin
          m_idx    = pick(found, m_rr);
          m_t0     = cyc;
          m_active = 1'b1;
        end
      end else if ((cyc - m_t0) == 1) begin
        m_slice = co_buf[m_idx*SW +: SW];
      end else if ((cyc - m_t0) == R - 1) begin
        m_count = m_count + 16'd1;
        m_rr    = (m_idx + 1) % NM;
      end
    end
    cyc++;
  end

  logic          e_tx, e_busy;
  logic [NM-1:0] e_res;
  logic [7:0]    e_byte;
  int            t, u, bitn, pos;

  always @(negedge clk) begin
    if (chk_en) begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
      e_res  = '0;
      if (m_active) begin
        t      = cyc - m_t0;
        e_busy = (t >= 1) && (t <= R + 2);
        u      = t - 3;
        if (u >= 0 && u < FRAME_CYC) begin
          bitn   = u / CPB;
          pos    = bitn % 10;
          e_byte = frame_byte(bitn / 10);
          if (pos == 0) e_tx = 1'b0;
          else if (pos == 9) e_tx = 1'b1;
          else e_tx = e_byte[pos-1];
        end
        if (t == R) e_res[m_idx] = 1'b1;
      end
      check("TX", tx, e_tx);
      check("busy", busy, e_busy);
      check("res", res, e_res);
      check("frame_count", frame_count, m_count);
    end
  end

  // UART decoder and res event log.
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         res_log[$];

  always @(negedge clk) begin
    if (!chk_en || !rst_n) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1) begin
        if (rx_cnt / CPB <= 8) begin
          rx_sh = {tx, rx_sh[7:1]};
        end else begin
          check("rx_stop", tx, 1'b1);
          rx_q.push_back(rx_sh);
          rx_busy = 1'b0;
        end
      end
    end
    if (chk_en && rst_n) begin
      for (int i = 0; i < NM; i++) if (res[i]) res_log.push_back(i);
    end
  end

  // Search-module emulation: drop found hold_ext cycles after seeing res, optionally re-raise.
  int drop_at[NM];
  int raise_at[NM];
  int hold_ext[NM];
  bit rearm[NM];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NM; i++) begin
        if (res[i]) drop_at[i] = cyc + 1 + hold_ext[i];
        if (cyc == drop_at[i]) begin
          found[i]   = 1'b0;
          drop_at[i] = -1;
          if (rearm[i]) raise_at[i] = cyc + 1;
        end
        if (cyc == raise_at[i]) begin
          found[i]    = 1'b1;
          raise_at[i] = -1;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    found = '0;
    for (int i = 0; i < NM; i++) begin
      drop_at[i] = -1; raise_at[i] = -1; hold_ext[i] = 0; rearm[i] = 1'b0;
    end
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_active || found != '0) && n < 3000) begin
      step(1);
      n++;
    end
    check({name, "_idle_timeout"}, n < 3000, 1'b1);
    step(5);
  endtask

  task automatic check_frame(input string name, input int base, input logic [63:0] exp);
    for (int k = 0; k < 8; k++) begin
      if (base + k < rx_q.size()) check(name, rx_q[base+k], exp[63-8*k -: 8]);
    end
  endtask

  task automatic clear_logs();
    rx_q.delete();
    res_log.delete();
  endtask

  initial begin
    int n;
    do_reset();
    chk_en = 1'b1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", frame_count, 16'd0);

    // 1: single hit
    clear_logs();
    co_buf[3*SW +: SW] = 48'h0102030405AB;
    found[3] = 1'b1;
    wait_idle("t1");
    check("t1_nbytes", rx_q.size(), 8);
    check_frame("t1_bytes", 0, 64'hA503_0102_0304_05AB);
    check("t1_nres", res_log.size(), 1);
    if (res_log.size() > 0) check("t1_res_idx", res_log[0], 3);
    check("t1_count", frame_count, 16'd1);

    // 2: simultaneous hits from reset
    do_reset();
    clear_logs();
    co_buf[2*SW +: SW] = 48'h202122232425;
    co_buf[7*SW +: SW] = 48'h707172737475;
    found[2] = 1'b1;
    found[7] = 1'b1;
    wait_idle("t2");
    check("t2_nbytes", rx_q.size(), 16);
    check_frame("t2_frame0", 0, 64'hA502_2021_2223_2425);
    check_frame("t2_frame1", 8, 64'hA507_7071_7273_7475);
    check("t2_nres", res_log.size(), 2);
    if (res_log.size() > 1) begin
      check("t2_res_first", res_log[0], 2);
      check("t2_res_second", res_log[1], 7);
    end
    check("t2_count", frame_count, 16'd2);

    // 3: round-robin between 0 and 29, both re-raised immediately
    do_reset();
    clear_logs();
    co_buf[0*SW +: SW]  = 48'h0A0B0C0D0E0F;
    co_buf[29*SW +: SW] = 48'h1D1D1D1D1D1D;
    rearm[0] = 1'b1;
    rearm[29] = 1'b1;
    found[0] = 1'b1;
    found[29] = 1'b1;
    n = 0;
    while (res_log.size() < 4 && n < 5000) begin
      step(1);
      n++;
    end
    check("t3_timeout", n < 5000, 1'b1);
    rearm[0] = 1'b0;
    rearm[29] = 1'b0;
    wait_idle("t3");
    if (res_log.size() >= 4) begin
      check("t3_order0", res_log[0], 0);
      check("t3_order1", res_log[1], 29);
      check("t3_order2", res_log[2], 0);
      check("t3_order3", res_log[3], 29);
    end
    if (rx_q.size() >= 32) begin
      check("t3_idx0", rx_q[1], 8'd0);
      check("t3_idx1", rx_q[9], 8'd29);
      check("t3_idx2", rx_q[17], 8'd0);
      check("t3_idx3", rx_q[25], 8'd29);
    end

    // 4: coefficient slice changes during SEND
    clear_logs();
    co_buf[10*SW +: SW] = 48'h112233445566;
    found[10] = 1'b1;
    step(20);
    co_buf[10*SW +: SW] = 48'hFFEEDDCCBBAA;
    wait_idle("t4");
    check("t4_nbytes", rx_q.size(), 8);
    check_frame("t4_bytes", 0, 64'hA50A_1122_3344_5566);

    // 5: reset during byte 3, then a fresh frame
    clear_logs();
    co_buf[5*SW +: SW] = 48'hDEADBEEF0102;
    found[5] = 1'b1;
    step(140);
    rst_n = 1'b0;
    found = '0;
    step(1);
    check("t5_tx", tx, 1'b1);
    check("t5_res", res, '0);
    check("t5_count", frame_count, 16'd0);
    check("t5_busy", busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < NM; i++) drop_at[i] = -1;
    step(2);
    check("t5_nres_abandoned", res_log.size(), 0);
    clear_logs();
    found[5] = 1'b1;
    wait_idle("t5");
    check("t5_nbytes", rx_q.size(), 8);
    check_frame("t5_bytes", 0, 64'hA505_DEAD_BEEF_0102);
    check("t5_count_after", frame_count, 16'd1);

    // 6: slow found drop, first within HOLD, then one cycle past it
    do_reset();
    clear_logs();
    co_buf[12*SW +: SW] = 48'hC0C1C2C3C4C5;
    hold_ext[12] = 2;
    found[12] = 1'b1;
    wait_idle("t6a");
    check("t6a_nres", res_log.size(), 1);
    check("t6a_count", frame_count, 16'd1);
    clear_logs();
    hold_ext[12] = 3;
    found[12] = 1'b1;
    n = 0;
    while (res_log.size() < 1 && n < 3000) begin
      step(1);
      n++;
    end
    check("t6b_timeout", n < 3000, 1'b1);
    hold_ext[12] = 0;
    wait_idle("t6b");
    check("t6b_nres", res_log.size(), 2);
    check("t6b_nbytes", rx_q.size(), 16);
    check("t6b_count", frame_count, 16'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
